// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package ifetch_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_W    = 64;
  localparam int unsigned ENTRY_W = INST_W + PC_W;  // 96-bit queue entry

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 64'h0;

  // Fetch control FSM encoding
  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StFetch  = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  // Queue entry layout: instruction word in the upper bits, its PC below
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } ifq_entry_t;

  // Word-align a fetch address
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO for fetched instructions, with flush, push, pop and an
// occupancy count. Flush takes priority over push and pop in the same cycle.
module ifq_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & ~i_flush & (r_count != '0);

  // Storage array; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (AW + 1)'(1);
      end
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues credit-limited requests to a synchronous
// ROM (one cycle latency) and queues {instruction, pc} for the consumer.
// Optional feature macro: IFETCH_PERF_EN enables saturating push/redirect
// counters; without it the perf outputs are tied to zero.
module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [PC_W-1:0]   o_rom_addr,
  input  logic [INST_W-1:0] i_rom_data,
  input  logic              i_redirect,
  input  logic [PC_W-1:0]   i_redirect_pc,
  input  logic              i_halt,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [PC_W-1:0]   o_inst_pc,
  output logic [31:0]       o_perf_fetch_cnt,
  output logic [31:0]       o_perf_flush_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic            w_fetch_en;
  logic [PC_W-1:0] r_fpc;
  logic [PC_W-1:0] r_req_pc;
  logic            r_inflight;
  logic            w_credit_ok;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  ifq_entry_t      w_wentry;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  ifq_entry_t      w_head;
  logic            w_unused_pc_lsb;

  // Low address bits of the redirect target are ignored
  assign w_unused_pc_lsb = ^i_redirect_pc[1:0];

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; a redirect overrides the normal transitions
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StBoot:   w_state_next = StFetch;
      StFetch:  if (i_halt) w_state_next = StHalted;
      StHalted: if (!i_halt) w_state_next = StFetch;
      default:  w_state_next = StBoot;
    endcase
    if (i_redirect) begin
      w_state_next = i_halt ? StHalted : StFetch;
    end
  end

  // FSM outputs
  always_comb begin
    w_fetch_en = 1'b0;
    if (r_state == StFetch) begin
      w_fetch_en = 1'b1;
    end
  end

  // Credit: queued entries plus the outstanding request must leave room
  assign w_credit_ok = ({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < (CW + 1)'(DEPTH);
  assign w_issue     = w_fetch_en & ~i_halt & ~i_redirect & w_credit_ok;

  // Fetch PC, outstanding-request tracking and the PC of the pending response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fpc      <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_fpc;
      end
      if (i_redirect) begin
        r_fpc <= align_pc(i_redirect_pc);
      end else if (w_issue) begin
        r_fpc <= r_fpc + 64'd4;
      end
    end
  end

  assign o_rom_addr = r_fpc;

  // A response landing in a redirect cycle belongs to the old stream
  assign w_push   = r_inflight & ~i_redirect;
  assign w_wentry = '{inst: i_rom_data, pc: r_req_pc};
  assign w_wdata  = w_wentry;

  assign o_inst_valid = ~w_empty & ~i_redirect;
  assign w_pop        = o_inst_valid & i_inst_ready;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ifq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Present zeros rather than stale storage when the queue is empty
  assign w_head    = w_rdata;
  assign o_inst    = w_empty ? '0 : w_head.inst;
  assign o_inst_pc = w_empty ? '0 : w_head.pc;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;

  // Saturating push and redirect counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_push && (r_perf_fetch != '1)) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (i_redirect && (r_perf_flush != '1)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign o_perf_fetch_cnt = r_perf_fetch;
  assign o_perf_flush_cnt = r_perf_flush;
`else
  assign o_perf_fetch_cnt = '0;
  assign o_perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer (DEPTH=4, RESET_PC=0). Stimulus pushes
// the hand-derived delivery sequence; a negedge monitor pops and compares on
// every accepted instruction and checks head stability while stalled.
module tb_ifetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;

  int checks = 0;
  int errors = 0;

  logic [95:0] exp_q[$];
  logic        hold_q = 1'b0;
  logic [95:0] hold_val;

  always #5 clk = ~clk;

  ifetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (64'h0)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_rom_addr       (rom_addr),
    .i_rom_data       (rom_data),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc),
    .i_halt           (halt),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .o_perf_fetch_cnt (perf_fetch_cnt),
    .o_perf_flush_cnt (perf_flush_cnt)
  );

  // ROM word n lives at byte address 4n and holds 32'h1000_0000 + n
  function automatic logic [31:0] rom_word(input logic [63:0] a);
    return 32'h1000_0000 + a[33:2];
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic expect_pc(input logic [63:0] pc);
    exp_q.push_back({rom_word(pc), pc});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compare each accepted head against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q && inst_valid) begin
        checks++;
        if ({inst, inst_pc} !== hold_val) begin
          errors++;
          $display("FAIL stable_head: got %h want %h", {inst, inst_pc}, hold_val);
        end
      end
      if (inst_valid && inst_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_inst: got pc %h inst %h want none", inst_pc, inst);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          if ({inst, inst_pc} !== e) begin
            errors++;
            $display("FAIL deliver: got inst %h pc %h want inst %h pc %h",
                     inst, inst_pc, e[95:64], e[63:0]);
          end
        end
      end
      hold_q   = inst_valid && !inst_ready;
      hold_val = {inst, inst_pc};
    end
  end

  initial begin
    logic [31:0] exp_fetch;
    logic [31:0] exp_flush;
`ifdef IFETCH_PERF_EN
    exp_fetch = 32'd25;
    exp_flush = 32'd2;
`else
    exp_fetch = 32'd0;
    exp_flush = 32'd0;
`endif
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    halt        = 1'b0;
    inst_ready  = 1'b1;

    // Reset values
    step(3);
    #3;
    chk("rst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_inst", {32'h0, inst}, 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_rom_addr", rom_addr, 64'h0);
    chk("rst_perf_fetch", {32'h0, perf_fetch_cnt}, 64'h0);
    chk("rst_perf_flush", {32'h0, perf_flush_cnt}, 64'h0);

    // Streaming after reset: 8 requests (cycles 1..8), halt in cycle 9
    for (int i = 0; i < 8; i++) expect_pc(64'(4 * i));
    step(1);
    rst_n = 1'b1;  // cycle 0 (BOOT)
    #3;
    chk("boot_addr", rom_addr, 64'h0);
    chk("boot_valid", {63'h0, inst_valid}, 64'h0);
    step(1);
    #3;
    chk("c1_addr", rom_addr, 64'h0);
    step(1);
    #3;
    chk("c2_addr", rom_addr, 64'h4);
    chk("c2_valid", {63'h0, inst_valid}, 64'h0);
    step(1);
    #3;
    chk("c3_valid", {63'h0, inst_valid}, 64'h1);
    step(6);
    halt = 1'b1;  // cycle 9; response of cycle-8 request still lands
    step(4);
    #3;
    chk("halt_drained", {63'h0, inst_valid}, 64'h0);
    chk("halt_addr", rom_addr, 64'h20);

    // Back-pressure: exactly 4 requests, then release and refetch without gaps
    for (int i = 0; i < 8; i++) expect_pc(64'h20 + 64'(4 * i));
    inst_ready = 1'b0;
    step(1);
    halt = 1'b0;
    step(8);
    inst_ready = 1'b1;
    #3;
    chk("stall_addr", rom_addr, 64'h30);
    chk("stall_valid", {63'h0, inst_valid}, 64'h1);
    chk("stall_head", inst_pc, 64'h20);
    for (int i = 0; i < 4; i++) begin
      step(1);
      #3;
      chk("no_gap", {63'h0, inst_valid}, 64'h1);
    end
    step(1);
    halt = 1'b1;
    step(5);
    #3;
    chk("stall_drained", {63'h0, inst_valid}, 64'h0);

    // Redirect with 3 queued entries and one response inflight
    for (int i = 0; i < 4; i++) expect_pc(64'h200 + 64'(4 * i));
    inst_ready = 1'b0;
    step(1);
    halt = 1'b0;
    step(5);
    redirect    = 1'b1;
    redirect_pc = 64'h203;
    #3;
    chk("redir_valid", {63'h0, inst_valid}, 64'h0);
    step(1);
    redirect   = 1'b0;
    inst_ready = 1'b1;
    #3;
    chk("redir_addr", rom_addr, 64'h200);
    step(4);
    halt = 1'b1;
    step(5);
    #3;
    chk("redir_drained", {63'h0, inst_valid}, 64'h0);

    // PC wrap: redirect while halted, then two fetches
    expect_pc(64'hFFFF_FFFF_FFFF_FFFC);
    expect_pc(64'h0);
    step(1);
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step(1);
    redirect = 1'b0;
    halt     = 1'b0;
    #3;
    chk("wrap_addr", rom_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(3);
    halt = 1'b1;
    step(5);
    #3;
    chk("wrap_drained", {63'h0, inst_valid}, 64'h0);
    chk("wrap_next", rom_addr, 64'h4);
    chk("perf_fetch", {32'h0, perf_fetch_cnt}, {32'h0, exp_fetch});
    chk("perf_flush", {32'h0, perf_flush_cnt}, {32'h0, exp_flush});

    // Reset mid-operation with a full queue: nothing old may be delivered
    inst_ready = 1'b0;
    step(1);
    halt = 1'b0;
    step(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'h0, inst_valid}, 64'h0);
    chk("midrst_addr", rom_addr, 64'h0);
    chk("midrst_perf", {32'h0, perf_fetch_cnt}, 64'h0);
    for (int i = 0; i < 3; i++) expect_pc(64'(4 * i));
    step(1);
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    step(4);
    halt = 1'b1;
    step(6);
    #3;
    chk("midrst_drained", {63'h0, inst_valid}, 64'h0);
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
